// File: rtl/branch_predictor.sv
// Bimodal branch direction predictor: a table of 2-bit saturating counters
// indexed by PC, looked up combinationally in ID and trained by EX-stage
// branch resolution. Also keeps saturating counts of resolved branches and
// mispredictions for performance monitoring.
module branch_predictor #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        branchD,
  input  logic [31:0] pcD,
  output logic        pred_takeD,
  input  logic        branchE,
  input  logic [31:0] pcE,
  input  logic        pred_takeE,
  input  logic        actual_takeE,
  input  logic        stallE,
  output logic        mispredictE,
  output logic [31:0] br_count,
  output logic [31:0] miss_count
);

  localparam int ENTRIES = 1 << INDEX_W;

  // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  localparam logic [1:0] WEAK_NT = 2'b01;

  // One step toward the resolved direction, clamped at either end.
  function automatic logic [1:0] pht_step(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken) begin
      if (cur != 2'b11) nxt = cur + 2'b01;
    end else begin
      if (cur != 2'b00) nxt = cur - 2'b01;
    end
    return nxt;
  endfunction

  // Event counters stick at all-ones rather than wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    logic [31:0] nxt;
    nxt = v;
    if (v != 32'hFFFF_FFFF) nxt = v + 32'd1;
    return nxt;
  endfunction

  logic [1:0]         pht [ENTRIES];
  logic [INDEX_W-1:0] idx_d;
  logic [INDEX_W-1:0] idx_e;
  logic               upd_e;
  logic               unused_pc_bits;

  assign idx_d = pcD[INDEX_W+1:2];
  assign idx_e = pcE[INDEX_W+1:2];

  // Only the index bits of either PC matter; byte offset and upper bits alias.
  assign unused_pc_bits = ^{pcD[31:INDEX_W+2], pcD[1:0], pcE[31:INDEX_W+2], pcE[1:0]};

  // A stalled EX branch is held until it leaves, so it trains and counts once.
  assign upd_e = branchE & ~stallE;

  // ID lookup reads the table directly, so a same-cycle write is not visible.
  assign pred_takeD = branchD & pht[idx_d][1];

  // Misprediction is raw; the hazard unit decides what to do while stalled.
  assign mispredictE = branchE & (pred_takeE ^ actual_takeE);

  // PHT training on each resolved, non-stalled EX branch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht[i] <= WEAK_NT;
      end
    end else if (upd_e) begin
      pht[idx_e] <= pht_step(pht[idx_e], actual_takeE);
    end
  end

  // Performance counters: resolved branches and mispredictions.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      br_count   <= '0;
      miss_count <= '0;
    end else if (upd_e) begin
      br_count <= sat_inc(br_count);
      if (mispredictE) begin
        miss_count <= sat_inc(miss_count);
      end
    end
  end

endmodule
